// File: rtl/fft_frame_io.sv
// rtl/fft_frame_io.sv - frame sequencer between sample streams and the FFT register file / core
//
// Purpose: accepts N complex samples on a valid/ready input stream and writes
// them into the register file through its load port, pulses the FFT core start,
// waits for done, then reads the N bins back and emits them on a registered
// valid/ready output stream with a last flag on bin N-1.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   s_valid/s_ready/s_re/s_im     input sample stream
//   load/load_addr/load_re/load_im register file write port
//   fft_start/fft_done            FFT core handshake (start is a one-cycle pulse)
//   rf_out_addr/rf_out_re/rf_out_im register file readback (data combinational from address)
//   m_valid/m_ready/m_re/m_im/m_last output bin stream
//   busy                          high whenever not collecting input samples
//
// Build option: FFT_FRAME_IO_BITREV_LOAD_EN - when defined, samples are written
// at bit-reversed addresses so an in-place DIT core sees its required input
// order; readback order is always natural.

module fft_frame_io #(
    parameter  int N        = 8,
    parameter  int WIDTH    = 12,
    parameter  int FRACTION = 8,
    localparam int AW       = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_re,
    input  logic [WIDTH-1:0] s_im,
    output logic             load,
    output logic [AW-1:0]    load_addr,
    output logic [WIDTH-1:0] load_re,
    output logic [WIDTH-1:0] load_im,
    output logic             fft_start,
    input  logic             fft_done,
    output logic [AW-1:0]    rf_out_addr,
    input  logic [WIDTH-1:0] rf_out_re,
    input  logic [WIDTH-1:0] rf_out_im,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_re,
    output logic [WIDTH-1:0] m_im,
    output logic             m_last,
    output logic             busy
);

    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] CNT_N    = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic              fft_start_q, fft_start_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic [WIDTH-1:0]  m_re_q, m_re_d;
    logic [WIDTH-1:0]  m_im_q, m_im_d;

`ifdef FFT_FRAME_IO_BITREV_LOAD_EN
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    assign load_addr = bitrev(wr_cnt_q[AW-1:0]);
`else
    assign load_addr = wr_cnt_q[AW-1:0];
`endif

    assign load_re     = s_re;
    assign load_im     = s_im;
    assign rf_out_addr = rd_cnt_q[AW-1:0];
    assign fft_start   = fft_start_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign m_re        = m_re_q;
    assign m_im        = m_im_q;
    assign busy        = (state_q != ST_LOAD);

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_re_d    = m_re_q;
        m_im_d    = m_im_q;
        s_ready   = 1'b0;
        load      = 1'b0;

        case (state_q)
            ST_LOAD: begin
                s_ready = 1'b1;
                // Write strobe is the accept itself so the register file
                // captures the sample on the same edge the stream hands it over.
                load = s_valid;
                if (s_valid) begin
                    if (wr_cnt_q == CNT_LAST) begin
                        wr_cnt_d = '0;
                        state_d  = ST_START;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CNT_ONE;
                    end
                end
            end

            ST_START: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // Done is only honoured here; a level left over from the
                // previous frame cannot skip the compute phase.
                if (fft_done) begin
                    state_d  = ST_UNLOAD;
                    rd_cnt_d = '0;
                end
            end

            ST_UNLOAD: begin
                if (m_valid_q && m_ready && m_last_q) begin
                    // Final bin taken: rd_cnt is already N, so nothing more to fetch.
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    rd_cnt_d  = '0;
                    state_d   = ST_LOAD;
                end else if ((!m_valid_q || m_ready) && (rd_cnt_q < CNT_N)) begin
                    m_re_d    = rf_out_re;
                    m_im_d    = rf_out_im;
                    m_valid_d = 1'b1;
                    m_last_d  = (rd_cnt_q == CNT_LAST);
                    rd_cnt_d  = rd_cnt_q + CNT_ONE;
                end else if (m_valid_q && m_ready && (rd_cnt_q == CNT_N)) begin
                    m_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Registered pulse: high exactly while the FSM sits in START.
        fft_start_d = (state_d == ST_START);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            fft_start_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_re_q      <= '0;
            m_im_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            fft_start_q <= fft_start_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_re_q      <= m_re_d;
            m_im_q      <= m_im_d;
        end
    end

endmodule
